// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the MEM stage (port 0) and the DMA/debug loader (port 1).
// Optional DMEM_ARB_PERF_EN adds 16-bit grant/conflict counters. Latency: ack two cycles after an uncontended req. A requester stalls until its ack arrives.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_readData
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_grant0,
    output logic [15:0]       perf_grant1,
    output logic [15:0]       perf_conflict
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY0 = 2'd1;
    localparam logic [1:0] ST_BUSY1 = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    logic elig0, elig1;
    logic grant0, grant1;
    logic busy0, busy1;

    // A request seen while its own ack is high is the one just completed, not a new one.
    assign elig0 = p0_req & ~p0_ack_q;
    assign elig1 = p1_req & ~p1_ack_q;
    assign busy0 = (state_q == ST_BUSY0);
    assign busy1 = (state_q == ST_BUSY1);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        grant0      = 1'b0;
        grant1      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (elig0 && (!elig1 || last_q)) begin
                    grant0 = 1'b1;
                end else if (elig1) begin
                    grant1 = 1'b1;
                end
            end
            ST_BUSY0: begin
                p0_ack_d = 1'b1;
                if (!cmd_we_q) begin
                    p0_rdata_d = mem_readData;
                end
                state_d = ST_IDLE;
                grant1  = elig1;
            end
            ST_BUSY1: begin
                p1_ack_d = 1'b1;
                if (!cmd_we_q) begin
                    p1_rdata_d = mem_readData;
                end
                state_d = ST_IDLE;
                grant0  = elig0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant0) begin
            cmd_we_d    = p0_we;
            cmd_addr_d  = p0_addr;
            cmd_wdata_d = p0_wdata;
            last_d      = 1'b0;
            state_d     = ST_BUSY0;
        end else if (grant1) begin
            cmd_we_d    = p1_we;
            cmd_addr_d  = p1_addr;
            cmd_wdata_d = p1_wdata;
            last_d      = 1'b1;
            state_d     = ST_BUSY1;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_grant0_q, perf_grant0_d;
    logic [15:0] perf_grant1_q, perf_grant1_d;
    logic [15:0] perf_conflict_q, perf_conflict_d;
    logic        conflict;

    assign conflict = ((state_q == ST_IDLE) & elig0 & elig1) | (busy0 & elig1) | (busy1 & elig0);

    always_comb begin
        perf_grant0_d   = perf_grant0_q + {15'd0, grant0};
        perf_grant1_d   = perf_grant1_q + {15'd0, grant1};
        perf_conflict_d = perf_conflict_q + {15'd0, conflict};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grant0_q   <= '0;
            perf_grant1_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_grant0_q   <= perf_grant0_d;
            perf_grant1_q   <= perf_grant1_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_grant0   = perf_grant0_q;
    assign perf_grant1   = perf_grant1_q;
    assign perf_conflict = perf_conflict_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    // Address/data follow the command registers so they hold their last value while idle.
    assign mem_address   = cmd_addr_q;
    assign mem_writeData = cmd_wdata_q;
    assign mem_memWrite  = (busy0 | busy1) & cmd_we_q;
    assign mem_memRead   = (busy0 | busy1) & ~cmd_we_q;

    assign p0_ack   = p0_ack_q;
    assign p1_ack   = p1_ack_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule
